cpu_core: RTL and testbench



---
 rtl/cpu_core.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_cpu_core.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// cpu_core: two-stage RV32I register-file datapath (decode/operand read, then execute/writeback).
// Define CPU_MUL_EN to add the RV32M MUL instruction; otherwise funct7=0000001 encodings are NOPs.

module cpu_core_regfile #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_we,
  input  logic [AW-1:0]   i_rd_addr,
  input  logic [XLEN-1:0] i_rd_data
);
  logic [XLEN-1:0] REGISTER_FILE [0:NUM_REGS-1];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        REGISTER_FILE[i[AW-1:0]] <= '0;
      end
    end else if (i_we && (i_rd_addr != '0)) begin
      REGISTER_FILE[i_rd_addr] <= i_rd_data;
    end
  end

  assign o_rs1_data = (i_rs1_addr == '0) ? '0 : REGISTER_FILE[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == '0) ? '0 : REGISTER_FILE[i_rs2_addr];
endmodule

module cpu_core #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] INSTRUCTION,
  input  logic [XLEN-1:0] READ_DATA,
  output logic            MEM_READ,
  output logic            MEM_WRITE,
  output logic [XLEN-1:0] MEM_WRITE_DATA,
  output logic [XLEN-1:0] MEM_ADDRESS
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
`ifdef CPU_MUL_EN
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;
`endif

  typedef enum logic [1:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE
  } op_class_e;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_MUL
  } alu_op_e;

  // Decode-stage fields
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [AW-1:0]   w_rd;
  logic [AW-1:0]   w_rs1;
  logic [AW-1:0]   w_rs2;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_u;

  op_class_e       w_class;
  alu_op_e         w_alu_op;
  logic            w_use_imm;
  logic            w_zero_a;
  logic [XLEN-1:0] w_imm;

  logic [XLEN-1:0] w_rf_rs1;
  logic [XLEN-1:0] w_rf_rs2;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;

  // D/E pipeline register
  logic            r_valid;
  op_class_e       r_class;
  alu_op_e         r_alu_op;
  logic [XLEN-1:0] r_op_a;
  logic [XLEN-1:0] r_op_b;
  logic [AW-1:0]   r_rd;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_store_data;

  // Execute-stage signals
  logic [XLEN-1:0] w_alu_result;
  logic [XLEN-1:0] w_mem_addr;
  logic            w_is_load;
  logic            w_is_store;
  logic [XLEN-1:0] w_wb_data;
  logic            w_wb_en;

  assign w_opcode = INSTRUCTION[6:0];
  assign w_rd     = INSTRUCTION[11:7];
  assign w_funct3 = INSTRUCTION[14:12];
  assign w_rs1    = INSTRUCTION[19:15];
  assign w_rs2    = INSTRUCTION[24:20];
  assign w_funct7 = INSTRUCTION[31:25];
  assign w_imm_i  = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
  assign w_imm_s  = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
  assign w_imm_u  = {INSTRUCTION[31:12], 12'b0};

  always_comb begin
    w_class   = CLS_NOP;
    w_alu_op  = ALU_ADD;
    w_use_imm = 1'b0;
    w_zero_a  = 1'b0;
    w_imm     = w_imm_i;
    case (w_opcode)
      OPC_OP: begin
        case (w_funct7)
          F7_BASE: begin
            w_class = CLS_ALU;
            case (w_funct3)
              3'b000: w_alu_op = ALU_ADD;
              3'b001: w_alu_op = ALU_SLL;
              3'b010: w_alu_op = ALU_SLT;
              3'b011: w_alu_op = ALU_SLTU;
              3'b100: w_alu_op = ALU_XOR;
              3'b101: w_alu_op = ALU_SRL;
              3'b110: w_alu_op = ALU_OR;
              3'b111: w_alu_op = ALU_AND;
            endcase
          end
          F7_ALT: begin
            if (w_funct3 == 3'b000) begin
              w_class  = CLS_ALU;
              w_alu_op = ALU_SUB;
            end else if (w_funct3 == 3'b101) begin
              w_class  = CLS_ALU;
              w_alu_op = ALU_SRA;
            end
          end
`ifdef CPU_MUL_EN
          F7_MULDIV: begin
            if (w_funct3 == 3'b000) begin
              w_class  = CLS_ALU;
              w_alu_op = ALU_MUL;
            end
          end
`endif
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        w_use_imm = 1'b1;
        case (w_funct3)
          3'b000: begin w_class = CLS_ALU; w_alu_op = ALU_ADD;  end
          3'b010: begin w_class = CLS_ALU; w_alu_op = ALU_SLT;  end
          3'b011: begin w_class = CLS_ALU; w_alu_op = ALU_SLTU; end
          3'b100: begin w_class = CLS_ALU; w_alu_op = ALU_XOR;  end
          3'b110: begin w_class = CLS_ALU; w_alu_op = ALU_OR;   end
          3'b111: begin w_class = CLS_ALU; w_alu_op = ALU_AND;  end
          3'b001: begin
            if (w_funct7 == F7_BASE) begin
              w_class  = CLS_ALU;
              w_alu_op = ALU_SLL;
            end
          end
          3'b101: begin
            if (w_funct7 == F7_BASE) begin
              w_class  = CLS_ALU;
              w_alu_op = ALU_SRL;
            end else if (w_funct7 == F7_ALT) begin
              w_class  = CLS_ALU;
              w_alu_op = ALU_SRA;
            end
          end
        endcase
      end
      OPC_LUI: begin
        w_class   = CLS_ALU;
        w_zero_a  = 1'b1;
        w_use_imm = 1'b1;
        w_imm     = w_imm_u;
      end
      OPC_LOAD: begin
        if (w_funct3 == 3'b010) w_class = CLS_LOAD;
      end
      OPC_STORE: begin
        if (w_funct3 == 3'b010) begin
          w_class = CLS_STORE;
          w_imm   = w_imm_s;
        end
      end
      default: ;
    endcase
  end

  cpu_core_regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) regfile (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .o_rs1_data (w_rf_rs1),
    .o_rs2_data (w_rf_rs2),
    .i_we       (w_wb_en),
    .i_rd_addr  (r_rd),
    .i_rd_data  (w_wb_data)
  );

  // E writes the register file on the same edge D samples it, so bypass E's result
  // (load data included) into D; this is what removes every stall.
  assign w_rs1_val = (w_wb_en && (w_rs1 == r_rd)) ? w_wb_data : w_rf_rs1;
  assign w_rs2_val = (w_wb_en && (w_rs2 == r_rd)) ? w_wb_data : w_rf_rs2;
  assign w_op_a    = w_zero_a  ? '0    : w_rs1_val;
  assign w_op_b    = w_use_imm ? w_imm : w_rs2_val;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid      <= 1'b0;
      r_class      <= CLS_NOP;
      r_alu_op     <= ALU_ADD;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_rd         <= '0;
      r_imm        <= '0;
      r_store_data <= '0;
    end else begin
      r_valid      <= (w_class != CLS_NOP);
      r_class      <= w_class;
      r_alu_op     <= w_alu_op;
      r_op_a       <= w_op_a;
      r_op_b       <= w_op_b;
      r_rd         <= w_rd;
      r_imm        <= w_imm;
      r_store_data <= w_rs2_val;
    end
  end

  always_comb begin
    w_alu_result = '0;
    case (r_alu_op)
      ALU_ADD:  w_alu_result = r_op_a + r_op_b;
      ALU_SUB:  w_alu_result = r_op_a - r_op_b;
      ALU_SLL:  w_alu_result = r_op_a << r_op_b[4:0];
      ALU_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(r_op_a) < $signed(r_op_b))};
      ALU_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, (r_op_a < r_op_b)};
      ALU_XOR:  w_alu_result = r_op_a ^ r_op_b;
      ALU_SRL:  w_alu_result = r_op_a >> r_op_b[4:0];
      ALU_SRA:  w_alu_result = $unsigned($signed(r_op_a) >>> r_op_b[4:0]);
      ALU_OR:   w_alu_result = r_op_a | r_op_b;
      ALU_AND:  w_alu_result = r_op_a & r_op_b;
`ifdef CPU_MUL_EN
      ALU_MUL:  w_alu_result = r_op_a * r_op_b;
`endif
      default:  w_alu_result = '0;
    endcase
  end

  assign w_is_load  = r_valid && (r_class == CLS_LOAD);
  assign w_is_store = r_valid && (r_class == CLS_STORE);
  assign w_mem_addr = r_op_a + r_imm;
  assign w_wb_data  = w_is_load ? READ_DATA : w_alu_result;
  assign w_wb_en    = r_valid && ((r_class == CLS_ALU) || (r_class == CLS_LOAD)) && (r_rd != '0);

  assign MEM_READ       = w_is_load;
  assign MEM_WRITE      = w_is_store;
  assign MEM_ADDRESS    = (w_is_load || w_is_store) ? w_mem_addr : '0;
  assign MEM_WRITE_DATA = w_is_store ? r_store_data : '0;
endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: architectural (in-order, no pipeline) model plus directed RV32I vectors.
module tb_cpu_core;
  logic        CLK;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic [31:0] READ_DATA;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [31:0] MEM_WRITE_DATA;
  logic [31:0] MEM_ADDRESS;

  cpu_core #(.XLEN(32), .NUM_REGS(32)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .INSTRUCTION    (INSTRUCTION),
    .READ_DATA      (READ_DATA),
    .MEM_READ       (MEM_READ),
    .MEM_WRITE      (MEM_WRITE),
    .MEM_WRITE_DATA (MEM_WRITE_DATA),
    .MEM_ADDRESS    (MEM_ADDRESS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Architectural model: instructions take effect one after another on m_regs.
  logic [31:0] m_regs [32];
  logic [31:0] m_e_ins   = '0;
  logic        m_e_valid = 1'b0;
  logic        exp_mr    = 1'b0;
  logic        exp_mw    = 1'b0;
  logic [31:0] exp_addr  = '0;
  logic [31:0] exp_wd    = '0;

  // kind: 0 = no effect, 1 = write rd with val, 2 = load (rd <= rdata), 3 = store val at addr
  function automatic void model_exec(input logic [31:0] ins, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] rdata,
                                     output int kind, output logic [31:0] val,
                                     output logic [31:0] addr);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    op    = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    kind  = 0;
    val   = '0;
    addr  = '0;
    if (op == 7'h33) begin
      if (f7 == 7'h00) begin
        kind = 1;
        case (f3)
          3'd0: val = a + b;
          3'd1: val = a << b[4:0];
          3'd2: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: val = (a < b) ? 32'd1 : 32'd0;
          3'd4: val = a ^ b;
          3'd5: val = a >> b[4:0];
          3'd6: val = a | b;
          3'd7: val = a & b;
        endcase
      end else if (f7 == 7'h20 && f3 == 3'd0) begin
        kind = 1; val = a - b;
      end else if (f7 == 7'h20 && f3 == 3'd5) begin
        kind = 1; val = $unsigned($signed(a) >>> b[4:0]);
      end
`ifdef CPU_MUL_EN
      else if (f7 == 7'h01 && f3 == 3'd0) begin
        kind = 1; val = a * b;
      end
`endif
    end else if (op == 7'h13) begin
      kind = 1;
      case (f3)
        3'd0: val = a + imm_i;
        3'd2: val = ($signed(a) < $signed(imm_i)) ? 32'd1 : 32'd0;
        3'd3: val = (a < imm_i) ? 32'd1 : 32'd0;
        3'd4: val = a ^ imm_i;
        3'd6: val = a | imm_i;
        3'd7: val = a & imm_i;
        3'd1: if (f7 == 7'h00) val = a << ins[24:20]; else kind = 0;
        3'd5: begin
          if (f7 == 7'h00) val = a >> ins[24:20];
          else if (f7 == 7'h20) val = $unsigned($signed(a) >>> ins[24:20]);
          else kind = 0;
        end
      endcase
    end else if (op == 7'h37) begin
      kind = 1; val = {ins[31:12], 12'h000};
    end else if (op == 7'h03 && f3 == 3'd2) begin
      kind = 2; addr = a + imm_i; val = rdata;
    end else if (op == 7'h23 && f3 == 3'd2) begin
      kind = 3; addr = a + imm_s; val = b;
    end
  endfunction

  initial begin
    int          k;
    logic [31:0] v;
    logic [31:0] ad;
    forever begin
      @(posedge CLK or posedge RESET);
      if (RESET) begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_e_valid = 1'b0;
        exp_mr = 1'b0; exp_mw = 1'b0; exp_addr = '0; exp_wd = '0;
      end else begin
        if (m_e_valid) begin
          model_exec(m_e_ins, m_regs[m_e_ins[19:15]], m_regs[m_e_ins[24:20]], READ_DATA, k, v, ad);
          if ((k == 1 || k == 2) && m_e_ins[11:7] != 5'd0) m_regs[m_e_ins[11:7]] = v;
        end
        m_e_ins   = INSTRUCTION;
        m_e_valid = 1'b1;
        model_exec(m_e_ins, m_regs[m_e_ins[19:15]], m_regs[m_e_ins[24:20]], 32'h0, k, v, ad);
        exp_mr   = (k == 2);
        exp_mw   = (k == 3);
        exp_addr = (k >= 2) ? ad : 32'h0;
        exp_wd   = (k == 3) ? v : 32'h0;
      end
    end
  end

  // Per-cycle comparison against the model, just after each rising edge.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      chk("mem_read",  {31'b0, MEM_READ},  {31'b0, exp_mr});
      chk("mem_write", {31'b0, MEM_WRITE}, {31'b0, exp_mw});
      chk("mem_addr",  MEM_ADDRESS,    exp_addr);
      chk("mem_wdata", MEM_WRITE_DATA, exp_wd);
      for (int i = 0; i < 32; i++)
        chk($sformatf("reg_x%0d", i), dut.regfile.REGISTER_FILE[i], m_regs[i]);
    end
  end

  logic [31:0] hold = '0;

  // Present one instruction; rdata is what memory returns while it sits in E.
  task automatic step(input logic [31:0] ins, input logic [31:0] rdata);
    INSTRUCTION = ins;
    READ_DATA   = hold;
    hold        = rdata;
    @(negedge CLK);
  endtask

  task automatic chkreg(input int n, input logic [31:0] val);
    chk($sformatf("dut_x%0d", n),   dut.regfile.REGISTER_FILE[n], val);
    chk($sformatf("model_x%0d", n), m_regs[n], val);
  endtask

  task automatic chkmem(input string tag, input logic mr, input logic mw,
                        input logic [31:0] addr, input logic [31:0] wd);
    chk({tag, "_rd"},    {31'b0, MEM_READ},  {31'b0, mr});
    chk({tag, "_wr"},    {31'b0, MEM_WRITE}, {31'b0, mw});
    chk({tag, "_addr"},  MEM_ADDRESS,    addr);
    chk({tag, "_wdata"}, MEM_WRITE_DATA, wd);
  endtask

  initial begin
    RESET = 1'b1; INSTRUCTION = '0; READ_DATA = '0;
    #10 RESET = 1'b0;
    #1;
    chkmem("reset", 1'b0, 1'b0, 32'h0, 32'h0);
    chkreg(1, 32'h0);
    chkreg(31, 32'h0);
    @(negedge CLK);

    // ADDI/ADDI/ADD with forwarding of x2
    step(32'h00100093, 0);
    step(32'h00200113, 0);
    step(32'h002081B3, 0);
    step(32'h00000000, 0);
    chkreg(1, 32'd1);
    chkreg(2, 32'd2);
    chkreg(3, 32'd3);

    // SUB, then illegal opcode and all-zero word
    step(32'h402082B3, 0);
    step(32'h00010001, 0);
    chkmem("nop_illegal", 1'b0, 1'b0, 32'h0, 32'h0);
    step(32'h00000000, 0);
    step(32'h00000000, 0);
    chkreg(5, 32'hFFFFFFFF);

    // SW x3,8(x0)
    step(32'h00302423, 0);
    chkmem("sw", 1'b0, 1'b1, 32'd8, 32'd3);
    step(32'h00000000, 0);
    chkmem("sw_after", 1'b0, 1'b0, 32'h0, 32'h0);

    // LW x4,4(x0) then load-use ADDI x7,x4,1
    step(32'h00402203, 32'hDEADBEEF);
    chkmem("lw", 1'b1, 1'b0, 32'd4, 32'h0);
    step(32'h00120393, 0);
    step(32'h00000000, 0);
    chkreg(4, 32'hDEADBEEF);
    chkreg(7, 32'hDEADBEF0);

    // LB is not supported: no strobe, no write
    step(32'h00400203, 32'h11111111);
    chkmem("lb_nop", 1'b0, 1'b0, 32'h0, 32'h0);
    step(32'h00000000, 0);
    chkreg(4, 32'hDEADBEEF);

    // ALU mix, back-to-back dependent, ending in a store of a forwarded value
    step(32'hFF800513, 0);  // ADDI  x10,x0,-8
    step(32'h40155593, 0);  // SRAI  x11,x10,1
    step(32'h01C55613, 0);  // SRLI  x12,x10,28
    step(32'h001526B3, 0);  // SLT   x13,x10,x1
    step(32'h00153733, 0);  // SLTU  x14,x10,x1
    step(32'h00C097B3, 0);  // SLL   x15,x1,x12
    step(32'h12345837, 0);  // LUI   x16,0x12345
    step(32'hFFF84893, 0);  // XORI  x17,x16,-1
    step(32'hFF182E23, 0);  // SW    x17,-4(x16)
    chkmem("sw_fwd", 1'b0, 1'b1, 32'h12344FFC, 32'hEDCBAFFF);
    step(32'h00000000, 0);
    chkreg(10, 32'hFFFFFFF8);
    chkreg(11, 32'hFFFFFFFC);
    chkreg(12, 32'h0000000F);
    chkreg(13, 32'd1);
    chkreg(14, 32'd0);
    chkreg(15, 32'h00008000);
    chkreg(16, 32'h12345000);
    chkreg(17, 32'hEDCBAFFF);

    // MUL x6,x2,x3
    step(32'h02310333, 0);
    step(32'h00000000, 0);
`ifdef CPU_MUL_EN
    chkreg(6, 32'd6);
`else
    chkreg(6, 32'd0);
`endif

    // Reset pulse while MUL sits in E: it must not write afterwards
    step(32'h02310333, 0);
    RESET = 1'b1; INSTRUCTION = '0;
    #2;
    chkmem("in_reset", 1'b0, 1'b0, 32'h0, 32'h0);
    RESET = 1'b0;
    @(negedge CLK);
    chkreg(6, 32'd0);
    chkreg(3, 32'd0);

    // ADDI x9,x0,5 writes normally, but is discarded by a reset while in E
    step(32'h00500493, 0);
    step(32'h00000000, 0);
    chkreg(9, 32'd5);
    step(32'h00500493, 0);
    RESET = 1'b1; INSTRUCTION = '0;
    #2;
    RESET = 1'b0;
    @(negedge CLK);
    chkreg(9, 32'd0);
    step(32'h00000000, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
